// File: rtl/rv64g_l1_vec_resp_collector_if.sv
// Vector-port bus between crossbar/bank arrays, the response collector and the vector LSU.
// Optional multi-hit status port is present only when RV64G_L1_COLLECT_MULTIHIT_CHK_EN is defined.
interface rv64g_l1_vec_resp_collector_if #(
  parameter int WAYS      = 8,
  parameter int TAG_W     = 53,
  parameter int NUM_BANKS = 8,
  parameter int NUM_LANES = 8
);
  logic                            flush_i;
  logic                            start_i;
  logic [NUM_LANES-1:0]            lane_valid_i;
  logic [NUM_LANES*TAG_W-1:0]      lane_tag_i;
  logic                            start_ready_o;
  logic [NUM_BANKS-1:0]            bank_rd_fire_i;
  logic [NUM_BANKS*3-1:0]          bank_src_lane_i;
  logic [NUM_BANKS*WAYS*64-1:0]    bank_rdata_way_i;
  logic [NUM_BANKS*WAYS*TAG_W-1:0] bank_tag_way_i;
  logic [NUM_BANKS*WAYS*2-1:0]     bank_state_way_i;
  logic                            resp_valid_o;
  logic                            resp_ready_i;
  logic [NUM_LANES*64-1:0]         resp_data_o;
  logic [NUM_LANES-1:0]            resp_hit_o;
  logic [NUM_LANES*3-1:0]          resp_way_o;
  logic [NUM_LANES-1:0]            resp_mask_o;
  logic                            busy_o;
  logic [1:0]                      dbg_state_o;
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
  logic [NUM_LANES-1:0]            resp_multihit_o;
`endif

  // Handshakes: start_i is taken only in a cycle where start_ready_o is high; a response
  // transfers in a cycle where resp_valid_o && resp_ready_i, and while resp_valid_o is high
  // and resp_ready_i is low every resp_* output holds its value.
  modport slave (
    input  flush_i, start_i, lane_valid_i, lane_tag_i,
    input  bank_rd_fire_i, bank_src_lane_i, bank_rdata_way_i, bank_tag_way_i, bank_state_way_i,
    input  resp_ready_i,
    output start_ready_o, resp_valid_o, resp_data_o, resp_hit_o, resp_way_o, resp_mask_o,
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
    output resp_multihit_o,
`endif
    output busy_o, dbg_state_o
  );

  modport master (
    output flush_i, start_i, lane_valid_i, lane_tag_i,
    output bank_rd_fire_i, bank_src_lane_i, bank_rdata_way_i, bank_tag_way_i, bank_state_way_i,
    output resp_ready_i,
    input  start_ready_o, resp_valid_o, resp_data_o, resp_hit_o, resp_way_o, resp_mask_o,
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
    input  resp_multihit_o,
`endif
    input  busy_o, dbg_state_o
  );
endinterface

// File: rtl/rv64g_l1_vec_resp_collector.sv
// Gathers conflict-serialised per-bank L1 returns into one per-lane hit/data vector response.
// Optional macro RV64G_L1_COLLECT_MULTIHIT_CHK_EN adds per-lane multi-way-hit reporting.
module rv64g_l1_vec_resp_collector #(
  parameter int WAYS      = 8,
  parameter int TAG_W     = 53,
  parameter int NUM_BANKS = 8,
  parameter int NUM_LANES = 8
) (
  input logic clk_i,
  input logic rst_ni,
  rv64g_l1_vec_resp_collector_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [NUM_BANKS-1:0]    r_fire_q;
  logic [2:0]              r_src_q    [NUM_BANKS];
  logic [TAG_W-1:0]        r_lane_tag [NUM_LANES];
  logic [NUM_LANES-1:0]    r_pending;
  logic [NUM_LANES-1:0]    r_mask;
  logic [NUM_LANES-1:0]    r_hit;
  logic [NUM_LANES*3-1:0]  r_way;
  logic [NUM_LANES*64-1:0] r_data;

  logic                    w_bank_hit  [NUM_BANKS];
  logic [2:0]              w_bank_way  [NUM_BANKS];
  logic [63:0]             w_bank_data [NUM_BANKS];
  logic [NUM_LANES-1:0]    w_cap;
  logic [2:0]              w_cap_bank  [NUM_LANES];
  logic [NUM_LANES-1:0]    w_pending_nxt;
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
  logic                    w_bank_multi [NUM_BANKS];
  logic [NUM_LANES-1:0]    r_multihit;
`endif

  // Per-bank way select against the tag of the lane that owns the registered access.
  // Ways are scanned high-to-low so the lowest matching way is the one left standing.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_hit[b]  = 1'b0;
      w_bank_way[b]  = '0;
      w_bank_data[b] = '0;
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
      w_bank_multi[b] = 1'b0;
`endif
      for (int w = WAYS - 1; w >= 0; w--) begin
        if ((bus.bank_state_way_i[(b*WAYS+w)*2 +: 2] != 2'b00) &&
            (bus.bank_tag_way_i[(b*WAYS+w)*TAG_W +: TAG_W] == r_lane_tag[r_src_q[b]])) begin
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
          w_bank_multi[b] = w_bank_multi[b] | w_bank_hit[b];
`endif
          w_bank_hit[b]  = 1'b1;
          w_bank_way[b]  = 3'(w);
          w_bank_data[b] = bus.bank_rdata_way_i[(b*WAYS+w)*64 +: 64];
        end
      end
    end
  end

  // Lane capture: banks scanned high-to-low so the lowest bank naming a pending lane wins.
  always_comb begin
    w_cap = '0;
    for (int l = 0; l < NUM_LANES; l++) w_cap_bank[l] = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (r_fire_q[b] && r_pending[r_src_q[b]]) begin
        w_cap[r_src_q[b]]      = 1'b1;
        w_cap_bank[r_src_q[b]] = 3'(b);
      end
    end
    w_pending_nxt = r_pending & ~w_cap;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (bus.start_i) w_state_nxt = (bus.lane_valid_i == '0) ? ST_RESP : ST_COLLECT;
        ST_COLLECT: if (w_pending_nxt == '0) w_state_nxt = ST_RESP;
        ST_RESP:    if (bus.resp_ready_i) w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fire_q  <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_hit     <= '0;
      r_way     <= '0;
      r_data    <= '0;
      for (int b = 0; b < NUM_BANKS; b++) r_src_q[b] <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_lane_tag[l] <= '0;
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
      r_multihit <= '0;
`endif
    end else if (bus.flush_i) begin
      r_fire_q  <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_hit     <= '0;
      r_way     <= '0;
      r_data    <= '0;
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
      r_multihit <= '0;
`endif
    end else begin
      // Accesses granted while idle belong to no request and are discarded here.
      r_fire_q <= (r_state == ST_IDLE) ? '0 : bus.bank_rd_fire_i;
      for (int b = 0; b < NUM_BANKS; b++) r_src_q[b] <= bus.bank_src_lane_i[b*3 +: 3];
      if (r_state == ST_IDLE && bus.start_i) begin
        r_mask    <= bus.lane_valid_i;
        r_pending <= bus.lane_valid_i;
        r_hit     <= '0;
        r_way     <= '0;
        r_data    <= '0;
        for (int l = 0; l < NUM_LANES; l++) r_lane_tag[l] <= bus.lane_tag_i[l*TAG_W +: TAG_W];
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
        r_multihit <= '0;
`endif
      end else if (r_state == ST_COLLECT) begin
        r_pending <= w_pending_nxt;
        for (int l = 0; l < NUM_LANES; l++) begin
          if (w_cap[l]) begin
            r_hit[l]          <= w_bank_hit[w_cap_bank[l]];
            r_way[l*3 +: 3]   <= w_bank_way[w_cap_bank[l]];
            r_data[l*64 +: 64] <= w_bank_data[w_cap_bank[l]];
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
            r_multihit[l]     <= w_bank_multi[w_cap_bank[l]];
`endif
          end
        end
      end
    end
  end

  assign bus.start_ready_o = (r_state == ST_IDLE);
  assign bus.busy_o        = (r_state != ST_IDLE);
  assign bus.resp_valid_o  = (r_state == ST_RESP);
  assign bus.resp_mask_o   = r_mask;
  assign bus.resp_hit_o    = r_hit;
  assign bus.resp_way_o    = r_way;
  assign bus.resp_data_o   = r_data;
  assign bus.dbg_state_o   = r_state;
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
  assign bus.resp_multihit_o = r_multihit;
`endif

endmodule

// File: tb/tb_rv64g_l1_vec_resp_collector.sv
// Directed bench for rv64g_l1_vec_resp_collector; expected values are hand-derived per scenario.
module tb_rv64g_l1_vec_resp_collector;
  localparam int WAYS  = 8;
  localparam int TAG_W = 53;
  localparam int NB    = 8;
  localparam int NL    = 8;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  rv64g_l1_vec_resp_collector_if #(.WAYS(WAYS), .TAG_W(TAG_W), .NUM_BANKS(NB), .NUM_LANES(NL)) bus ();

  rv64g_l1_vec_resp_collector #(.WAYS(WAYS), .TAG_W(TAG_W), .NUM_BANKS(NB), .NUM_LANES(NL)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] mk_data(int b, int w, int gen);
    return 64'hDA7A_0000_0000_0000 | (64'(gen) << 24) | (64'(b) << 16) | (64'(w) << 8) | 64'h5A;
  endfunction

  function automatic logic [TAG_W-1:0] lane_tag(int l);
    return 53'h0AB_CDEF_0000 + 53'(l);
  endfunction

  task automatic set_way(int b, int w, logic [TAG_W-1:0] tag, logic [1:0] st, logic [63:0] data);
    bus.bank_tag_way_i[(b*WAYS+w)*TAG_W +: TAG_W] = tag;
    bus.bank_state_way_i[(b*WAYS+w)*2 +: 2]       = st;
    bus.bank_rdata_way_i[(b*WAYS+w)*64 +: 64]     = data;
  endtask

  // Every way valid but carrying a tag no lane ever uses.
  task automatic clear_banks();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < WAYS; w++)
        set_way(b, w, 53'h1_5555_0000 | 53'(b*WAYS+w), 2'b01, mk_data(b, w, 0));
  endtask

  task automatic drive_idle();
    bus.flush_i         = 1'b0;
    bus.start_i         = 1'b0;
    bus.lane_valid_i    = '0;
    bus.bank_rd_fire_i  = '0;
    bus.bank_src_lane_i = '0;
    bus.resp_ready_i    = 1'b0;
    for (int l = 0; l < NL; l++) bus.lane_tag_i[l*TAG_W +: TAG_W] = lane_tag(l);
    clear_banks();
  endtask

  task automatic drive_start(logic [NL-1:0] lv);
    bus.start_i      = 1'b1;
    bus.lane_valid_i = lv;
    step();
    bus.start_i      = 1'b0;
    bus.lane_valid_i = '0;
  endtask

  task automatic fire(int b, int lane);
    bus.bank_rd_fire_i[b]          = 1'b1;
    bus.bank_src_lane_i[b*3 +: 3]  = 3'(lane);
  endtask

  // ---------------- scoreboard of expected responses ----------------
  logic [63:0] exp_q[$];

  // ---------------- tests ----------------
  task automatic test_reset();
    total++; if (bus.resp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.resp_valid_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    total++; if (bus.start_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.start_ready_o); end
    total++; if (bus.resp_hit_o !== 8'h00 || bus.resp_mask_o !== 8'h00) begin
      bad++; $display("FAIL reset_hit_mask got=%h/%h exp=00/00", bus.resp_hit_o, bus.resp_mask_o); end
    total++; if (bus.resp_data_o !== '0 || bus.resp_way_o !== '0) begin
      bad++; $display("FAIL reset_data_way got=%h/%h exp=0", bus.resp_data_o, bus.resp_way_o); end
  endtask

  task automatic test_all_lanes();
    drive_start(8'hFF);
    for (int b = 0; b < NB; b++) begin
      set_way(b, 3, lane_tag(b), 2'b10, mk_data(b, 3, 1));
      fire(b, b);
      exp_q.push_back(mk_data(b, 3, 1));
    end
    step();
    bus.bank_rd_fire_i = '0;
    total++; if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      bad++; $display("FAIL all_lanes_early got=%b/%b exp=0/1", bus.resp_valid_o, bus.busy_o); end
    step();
    total++; if (bus.resp_valid_o !== 1'b1) begin bad++; $display("FAIL all_lanes_valid got=%b exp=1", bus.resp_valid_o); end
    total++; if (bus.resp_hit_o !== 8'hFF || bus.resp_mask_o !== 8'hFF) begin
      bad++; $display("FAIL all_lanes_hit_mask got=%h/%h exp=ff/ff", bus.resp_hit_o, bus.resp_mask_o); end
    total++; if (bus.resp_way_o !== {8{3'd3}}) begin bad++; $display("FAIL all_lanes_way got=%h exp=%h", bus.resp_way_o, {8{3'd3}}); end
    for (int l = 0; l < NL; l++) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      total++; if (bus.resp_data_o[l*64 +: 64] !== e) begin
        bad++; $display("FAIL all_lanes_data lane=%0d got=%h exp=%h", l, bus.resp_data_o[l*64 +: 64], e); end
    end
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
    total++; if (bus.resp_multihit_o !== 8'h00) begin bad++; $display("FAIL all_lanes_multihit got=%h exp=00", bus.resp_multihit_o); end
`endif
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    total++; if (bus.busy_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
      bad++; $display("FAIL all_lanes_release got=%b/%b exp=0/0", bus.busy_o, bus.resp_valid_o); end
    clear_banks();
  endtask

  // Lanes 0 and 1 serialised on bank 2; bank 6 duplicates lane 0 (lower bank wins);
  // bank 4 returns for unmasked lane 7 (ignored).
  task automatic test_conflict();
    drive_start(8'h03);
    fire(2, 0); fire(6, 0);
    step();
    bus.bank_rd_fire_i = '0;
    set_way(2, 5, lane_tag(0), 2'b11, mk_data(2, 5, 2));
    set_way(6, 1, lane_tag(0), 2'b11, mk_data(6, 1, 2));
    fire(2, 1); fire(4, 7);
    step();
    bus.bank_rd_fire_i = '0;
    total++; if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
      bad++; $display("FAIL conflict_partial got=%b/%b exp=0/1", bus.resp_valid_o, bus.busy_o); end
    clear_banks();
    set_way(2, 2, lane_tag(1), 2'b01, mk_data(2, 2, 3));
    set_way(4, 0, lane_tag(7), 2'b01, mk_data(4, 0, 3));
    step();
    clear_banks();
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.resp_valid_o !== 1'b1 || bus.resp_mask_o !== 8'h03 || bus.resp_hit_o !== 8'h03) begin
        bad++; $display("FAIL conflict_vmh cyc=%0d got=%b/%h/%h exp=1/03/03", k, bus.resp_valid_o, bus.resp_mask_o, bus.resp_hit_o); end
      total++; if (bus.resp_way_o !== 24'h000015) begin bad++; $display("FAIL conflict_way cyc=%0d got=%h exp=000015", k, bus.resp_way_o); end
      total++; if (bus.resp_data_o[63:0] !== mk_data(2, 5, 2) || bus.resp_data_o[127:64] !== mk_data(2, 2, 3) ||
                   bus.resp_data_o[511:128] !== '0) begin
        bad++; $display("FAIL conflict_data cyc=%0d got=%h", k, bus.resp_data_o[127:0]); end
      if (k < 2) step();
    end
    bus.resp_ready_i = 1'b1;
    step();
    bus.resp_ready_i = 1'b0;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL conflict_release got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_empty();
    drive_start(8'h00);
    for (int k = 0; k < 4; k++) begin
      total++; if (bus.resp_valid_o !== 1'b1 || bus.resp_hit_o !== 8'h00 || bus.resp_mask_o !== 8'h00 ||
                   bus.start_ready_o !== 1'b0) begin
        bad++; $display("FAIL empty_hold cyc=%0d got=%b/%h/%h/%b exp=1/00/00/0", k, bus.resp_valid_o,
                        bus.resp_hit_o, bus.resp_mask_o, bus.start_ready_o); end
      if (k < 3) step();
    end
    // start offered together with ready in RESP must not be taken
    bus.resp_ready_i = 1'b1; bus.start_i = 1'b1; bus.lane_valid_i = 8'h01;
    step();
    bus.resp_ready_i = 1'b0; bus.start_i = 1'b0; bus.lane_valid_i = '0;
    total++; if (bus.busy_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin
      bad++; $display("FAIL empty_release got=%b/%b exp=0/1", bus.busy_o, bus.start_ready_o); end
    step();
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL empty_start_ignored got=%b exp=0", bus.busy_o); end
  endtask

  task automatic test_invalid_state();
    drive_start(8'h10);
    set_way(0, 6, lane_tag(4), 2'b00, mk_data(0, 6, 4));
    fire(0, 4);
    step();
    bus.bank_rd_fire_i = '0;
    step();
    total++; if (bus.resp_valid_o !== 1'b1 || bus.resp_mask_o !== 8'h10 || bus.resp_hit_o !== 8'h00) begin
      bad++; $display("FAIL inv_state_hit got=%b/%h/%h exp=1/10/00", bus.resp_valid_o, bus.resp_mask_o, bus.resp_hit_o); end
    total++; if (bus.resp_way_o !== '0 || bus.resp_data_o !== '0) begin
      bad++; $display("FAIL inv_state_way_data got=%h/%h exp=0/0", bus.resp_way_o, bus.resp_data_o[319:256]); end
    bus.resp_ready_i = 1'b1; step(); bus.resp_ready_i = 1'b0;
    clear_banks();
  endtask

  task automatic test_idle_fire_drop();
    set_way(0, 4, lane_tag(0), 2'b10, mk_data(0, 4, 5));
    fire(0, 0);
    step();
    bus.start_i = 1'b1; bus.lane_valid_i = 8'h01;
    step();
    bus.start_i = 1'b0; bus.lane_valid_i = '0; bus.bank_rd_fire_i = '0;
    step(); step();
    total++; if (bus.busy_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
      bad++; $display("FAIL idle_fire_dropped got=%b/%b exp=1/0", bus.busy_o, bus.resp_valid_o); end
    fire(0, 0);
    step();
    bus.bank_rd_fire_i = '0;
    step();
    total++; if (bus.resp_valid_o !== 1'b1 || bus.resp_hit_o !== 8'h01 || bus.resp_way_o[2:0] !== 3'd4 ||
                 bus.resp_data_o[63:0] !== mk_data(0, 4, 5)) begin
      bad++; $display("FAIL idle_fire_real got=%b/%h/%h/%h", bus.resp_valid_o, bus.resp_hit_o, bus.resp_way_o, bus.resp_data_o[63:0]); end
    bus.resp_ready_i = 1'b1; step(); bus.resp_ready_i = 1'b0;
    clear_banks();
  endtask

  task automatic test_flush();
    drive_start(8'hFF);
    for (int b = 0; b < 4; b++) begin
      set_way(b, 0, lane_tag(b), 2'b01, mk_data(b, 0, 6));
      fire(b, b);
    end
    step();
    bus.bank_rd_fire_i = '0;
    step();
    total++; if (bus.busy_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_pre got=%b/%b exp=1/0", bus.busy_o, bus.resp_valid_o); end
    bus.flush_i = 1'b1;
    fire(4, 4);
    step();
    bus.flush_i = 1'b0;
    bus.bank_rd_fire_i = '0;
    total++; if (bus.busy_o !== 1'b0 || bus.start_ready_o !== 1'b1 || bus.resp_hit_o !== 8'h00 ||
                 bus.resp_mask_o !== 8'h00) begin
      bad++; $display("FAIL flush_idle got=%b/%b/%h/%h exp=0/1/00/00", bus.busy_o, bus.start_ready_o,
                      bus.resp_hit_o, bus.resp_mask_o); end
    drive_start(8'h00);
    total++; if (bus.resp_valid_o !== 1'b1 || bus.resp_mask_o !== 8'h00) begin
      bad++; $display("FAIL flush_restart got=%b/%h exp=1/00", bus.resp_valid_o, bus.resp_mask_o); end
    bus.resp_ready_i = 1'b1; step(); bus.resp_ready_i = 1'b0;
    // asynchronous reset mid-collect
    drive_start(8'h0F);
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin
      bad++; $display("FAIL async_reset got=%b/%b exp=0/1", bus.busy_o, bus.start_ready_o); end
    step();
    rst_n = 1'b1;
    step();
    clear_banks();
  endtask

  task automatic test_multihit();
    drive_start(8'h04);
    set_way(7, 5, lane_tag(2), 2'b01, mk_data(7, 5, 7));
    set_way(7, 1, lane_tag(2), 2'b11, mk_data(7, 1, 7));
    fire(7, 2);
    step();
    bus.bank_rd_fire_i = '0;
    step();
    total++; if (bus.resp_valid_o !== 1'b1 || bus.resp_hit_o !== 8'h04 || bus.resp_way_o[8:6] !== 3'd1 ||
                 bus.resp_data_o[191:128] !== mk_data(7, 1, 7)) begin
      bad++; $display("FAIL multihit_lowest got=%b/%h/%h/%h", bus.resp_valid_o, bus.resp_hit_o,
                      bus.resp_way_o, bus.resp_data_o[191:128]); end
`ifdef RV64G_L1_COLLECT_MULTIHIT_CHK_EN
    total++; if (bus.resp_multihit_o !== 8'h04) begin bad++; $display("FAIL multihit_flag got=%h exp=04", bus.resp_multihit_o); end
`endif
    bus.resp_ready_i = 1'b1; step(); bus.resp_ready_i = 1'b0;
    clear_banks();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    step(); step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_all_lanes();
    test_conflict();
    test_empty();
    test_invalid_state();
    test_idle_fire_drop();
    test_flush();
    test_multihit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/rv64g_l1_vec_resp_collector.md
Name: rv64g_l1_vec_resp_collector

Overview:
- Sits directly downstream of the banked L1 arrays on the vector port.
- Consumes per-bank way-wide read data, tags and states, routed by the crossbar's per-bank source-lane tag.
- Gathers per-lane results over one or more conflict-serialised cycles, does per-lane tag match and way select, and presents one packed, per-lane hit/data response to the vector LSU under a valid/ready handshake.

Parameters:
- WAYS, 8, associativity; way index is 3 bits.
- TAG_W, 53, tag width.
- NUM_BANKS, 8, bank count; must equal 8 (src-lane field is 3 bits).
- NUM_LANES, 8, vector lanes; must equal 8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low.
- flush_i  in  1  synchronous abort; returns the block to IDLE.
- start_i  in  1  vector request accepted by crossbar this cycle.
- lane_valid_i  in  NUM_LANES  active lanes of the request.
- lane_tag_i  in  NUM_LANES*TAG_W  per-lane lookup tag.
- start_ready_o  out  1  high only in IDLE.
- bank_rd_fire_i  in  NUM_BANKS  vector access granted to bank this cycle.
- bank_src_lane_i  in  NUM_BANKS*3  lane owning each granted bank access.
- bank_rdata_way_i  in  NUM_BANKS*WAYS*64  bank read data, all ways.
- bank_tag_way_i  in  NUM_BANKS*WAYS*TAG_W  bank tags, all ways.
- bank_state_way_i  in  NUM_BANKS*WAYS*2  bank states, all ways.
- resp_valid_o  out  1  response available.
- resp_ready_i  in  1  consumer accepts response.
- resp_data_o  out  NUM_LANES*64  per-lane hit-way data word.
- resp_hit_o  out  NUM_LANES  per-lane hit.
- resp_way_o  out  NUM_LANES*3  per-lane hit way.
- resp_mask_o  out  NUM_LANES  lanes valid in this response (latched lane_valid_i).
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE; pending/mask/hit/data/way registers cleared; resp_valid_o=0, busy_o=0, start_ready_o=1.
- Bank read latency is 1 cycle. bank_rd_fire_i and bank_src_lane_i are registered (fire_q, src_q). Bank arrays are sampled in the cycle after the fire.
- IDLE:
  - start_i latches lane_valid_i into mask and pending, and lane_tag_i into per-lane tag regs.
  - Go to RESP if lane_valid_i==0, else COLLECT.
  - Fires seen in IDLE are dropped; fire_q is forced 0 in IDLE.
- COLLECT, for each bank b with fire_q[b]=1 and pending[src_q[b]]=1:
  - For every way w, compute match_w = (state!=2'b00) && (tag==lane tag).
  - hit = OR(match_w); way = lowest-index match (0 when no hit); data = rdata of that way (0 when no hit).
  - Store into lane src_q[b] and clear its pending bit.
  - Returns for non-pending lanes (duplicate or stray) are ignored.
  - Two banks naming the same pending lane in one cycle: the lowest bank index wins.
  - When pending (after this cycle's updates) is 0, go to RESP on the next edge. The response is registered, so resp_valid_o rises the cycle after the last return is captured.
- RESP:
  - resp_valid_o=1; outputs are stable while valid && !ready.
  - On resp_ready_i, go to IDLE. start_i in the same cycle is not accepted (start_ready_o is 0 in RESP).
- start_i outside IDLE is ignored.
- flush_i takes priority over everything:
  - Next state is IDLE; pending, fire_q and the response registers are cleared.
  - resp_valid_o drops the next cycle.
  - Asserting rst_ni low mid-operation has the same effect asynchronously.
- Lanes not in mask always report hit=0, way=0, data=0.

Optional Feature:
- Macro RV64G_L1_COLLECT_MULTIHIT_CHK_EN.
- When defined, adds output resp_multihit_o [NUM_LANES]: set for a lane whose capture saw more than one matching way; cleared on start and flush; valid with resp_valid_o. Lowest-way selection is unchanged.
- When undefined, the port and its logic are absent.

Test Plan:
- Start with lane_valid=8'hFF, one cycle with all 8 banks firing, src_q lanes 0..7, each tag matching way 3 -> resp_valid_o two cycles after the fire, resp_hit_o=8'hFF, all resp_way_o=3, data equal to way-3 words.
- Start with lane_valid=8'h03, where lanes 0 and 1 conflict on bank 2 and fire on consecutive cycles -> response after second capture; lane 0 data from first cycle, lane 1 from second; resp_mask_o=8'h03.
- Start with lane_valid=8'h00 -> resp_valid_o the cycle after start, resp_hit_o=0; hold resp_ready_i=0 for 3 cycles and outputs stay stable; ready=1 returns to IDLE.
- Lane 4: tag matches way 6 but state=2'b00, no other match -> resp_hit_o[4]=0, way=0, data=0.
- flush_i asserted mid-COLLECT with pending=8'hF0 -> busy_o=0 next cycle, resp_valid_o never asserts; a new start is accepted the following cycle.
- With RV64G_L1_COLLECT_MULTIHIT_CHK_EN defined, lane 2 matches ways 1 and 5 -> resp_way_o[2]=1 and resp_multihit_o[2]=1.
